mem_bus_arb: RTL and testbench
==============================

Name: mem_bus_arb

Overview:
Shares one single-port data/instruction memory between two masters: the mem stage (m0, data) and instruction fetch (m1).
- Sequences sub-word stores (SB/SH) as a two-beat read-modify-write, so the memory only ever sees full-word writes.
- Raises a pipeline hold while a data access is outstanding.
- Sits between the mem stage / ifetch and the memory slave.

Parameters:
ADDR_W, 32, address width of all address ports; data width fixed at 32.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_req_i  in  1  data access request
m0_we_i  in  1  1=store, 0=load
m0_size_i  in  2  00 byte, 01 half, 10 word (11 treated as word)
m0_addr_i  in  ADDR_W  byte address
m0_wdata_i  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
m0_rdata_o  out  32  full aligned word read
m0_ack_o  out  1  access complete, one-cycle pulse
m1_req_i  in  1  fetch request (read only)
m1_addr_i  in  ADDR_W  fetch address
m1_rdata_o  out  32  fetched word
m1_ack_o  out  1  fetch complete, one-cycle pulse
int_assert_i  in  1  interrupt being taken; blocks new m0 grants
s_req_o  out  1  slave request
s_we_o  out  1  slave write enable
s_addr_o  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
s_wdata_o  out  32  slave write word
s_rdata_i  in  32  slave read data, valid the cycle after a read request
hold_o  out  1  pipeline hold: m0_req_i & ~m0_ack_o

Behaviour:
- Single synchronous reset, rst=1 sampled at the clk edge. Polarity and synchronicity fixed.
- Reset clears state to IDLE, owner to 0 and the RR pointer to 0. In the first cycle after reset, every output is 0.
- Reset mid-RD or mid-RMW abandons the access: no write is issued and no ack is given.
- States: IDLE, RD, RMW.
- Handshake: a master holds req/addr/we/size/wdata stable until its ack. At grant the arbiter latches owner, address, size and wdata.
- IDLE: pick a requester (fixed priority, m0 over m1). An m0 request is not eligible while int_assert_i=1; m1 is still granted that cycle. Slave signals are driven combinationally in the grant cycle.
  - m0 word store: s_req=1, s_we=1, s_wdata=m0_wdata_i, and m0_ack_o=1 in the same cycle. Stay in IDLE. Latency 0.
  - m0 load, or m1 fetch: s_req=1, s_we=0, go to RD.
  - m0 byte/half store: s_req=1, s_we=0 on the aligned address, go to RMW.
- RD: forward s_rdata_i to the owner's rdata port with that owner's ack=1, then go to IDLE. Load latency 1. A new grant is not taken in RD; the earliest next grant is the following cycle.
- RMW: s_req=1, s_we=1, s_wdata = s_rdata_i with the selected lanes replaced. Assert m0_ack_o and go to IDLE.
  - Byte lane = addr[1:0].
  - Half: addr[1]=0 gives lanes [15:0], addr[1]=1 gives [31:16]; addr[0] ignored.
- An RMW or RD in progress always completes, whatever the value of int_assert_i.
- rdata ports hold their last value when not acked. Loads return the whole aligned word; byte/half extraction and sign extension stay in the mem stage.
- Word accesses ignore addr[1:0]. No misalignment exception is raised.
- Simultaneous m0 and m1 requests in IDLE: m0 wins (fixed priority). m1 waits, and its ack never coincides with m0_ack_o.

Optional Feature:
MEM_BUS_ARB_RR_EN
- Defined: round-robin grant. A 1-bit pointer marks the last granted master and the other master wins ties. The pointer updates on each grant and resets to 0, so m0 wins the first tie.
- Undefined: fixed priority, m0 always wins. Ifetch can starve during store bursts, which is acceptable because hold_o freezes fetch anyway.

Decomposition:
- defines.v (shared) gains:
  - size encodings SIZE_B/SIZE_H/SIZE_W
  - state encodings ARB_IDLE/ARB_RD/ARB_RMW
  - reuse of RIB_REQ/RIB_NREQ, WriteEnable/WriteDisable, ZeroWord, INT_ASSERT
- One sub-module: mem_lane_merge, combinational. Inputs old word, new data, size, addr[1:0]; output merged word.

Test Plan:
- Reset: rst=1 for 2 cycles with m0_req_i=1 → all outputs 0; first s_req_o is in the cycle after rst falls.
- SW 0xDEADBEEF at 0x104 → same cycle: s_we=1, s_addr=0x104, s_wdata=0xDEADBEEF, m0_ack=1, hold_o=0.
- Mem[0x100]=0x11223344; SB 0xAA at 0x102 → cycle0 read 0x100; cycle1 write 0x11AA3344, m0_ack=1, hold_o=1 in cycle0 only.
- SH 0xBEEF at 0x102, mem 0x11223344 → write 0xBEEF3344. LW 0x100 → m0_rdata=0x11223344 one cycle later.
- m0 load and m1 fetch both requested → m0 acked first; m1 granted next IDLE, acked 2 cycles later. With RR_EN, a second simultaneous pair serves m1 first.
- int_assert_i=1 with m0 SW and m1 pending → m1 granted, no write issued. int_assert_i rising during RMW cycle0 → write still issued and acked.

Source files
------------

// File: rtl/mem_bus_arb_pkg.sv
// Shared encodings for the data/ifetch memory arbiter: access sizes, FSM states
// and bus constants, plus byte-lane helpers used by the store merge path.
package mem_bus_arb_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_RD   = 2'b01,
    ARB_RMW  = 2'b10
  } arb_state_e;

  localparam logic        RIB_REQ      = 1'b1;
  localparam logic        RIB_NREQ     = 1'b0;
  localparam logic        WriteEnable  = 1'b1;
  localparam logic        WriteDisable = 1'b0;
  localparam logic        INT_ASSERT   = 1'b1;
  localparam logic [31:0] ZeroWord     = 32'h0000_0000;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SIZE_B) || (size == SIZE_H);
  endfunction

  // Size 2'b11 falls through to a full-word mask.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    case (size)
      SIZE_B:  mask = 4'b0001 << addr_lo;
      SIZE_H:  mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational byte-lane merge: replaces the lanes selected by size/addr[1:0]
// in the old memory word with right-aligned store data.
module mem_lane_merge
  import mem_bus_arb_pkg::*;
(
  input  logic [31:0] old_word_i,
  input  logic [31:0] new_data_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o
);

  logic [31:0] rep_data;
  logic [3:0]  mask;

  // Replicate the store data so every candidate lane already holds it.
  always_comb begin
    case (size_i)
      SIZE_B:  rep_data = {4{new_data_i[7:0]}};
      SIZE_H:  rep_data = {2{new_data_i[15:0]}};
      default: rep_data = new_data_i;
    endcase
  end

  assign mask = lane_mask(size_i, addr_lo_i);

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_o[gi*8 +: 8] = mask[gi] ? rep_data[gi*8 +: 8] : old_word_i[gi*8 +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_bus_arb.sv
// Arbiter sharing one single-port memory between the mem stage (m0) and ifetch (m1).
// Sub-word stores become read-modify-write. Define MEM_BUS_ARB_RR_EN for round-robin ties.
module mem_bus_arb
  import mem_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [1:0]        m0_size_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  output logic [31:0]       m0_rdata_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  output logic [31:0]       m1_rdata_o,
  output logic              m1_ack_o,
  input  logic              int_assert_i,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [31:0]       s_wdata_o,
  input  logic [31:0]       s_rdata_i,
  output logic              hold_o
);

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       m0_rdata_q, m1_rdata_q;

  logic              m0_elig;
  logic              pick_m0, pick_m1;
  logic              grant_m0, grant_m1;
  logic              m0_rd_fwd, m1_rd_fwd;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       merged_word;

  assign m0_elig = m0_req_i && (int_assert_i != INT_ASSERT);

`ifdef MEM_BUS_ARB_RR_EN
  // Set when m0 took the last grant, handing the next tie to m1.
  logic rr_ptr_q;

  assign pick_m0 = m0_elig && (!m1_req_i || !rr_ptr_q);
  assign pick_m1 = m1_req_i && !pick_m0;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else if (grant_m0 || grant_m1) begin
      rr_ptr_q <= grant_m0;
    end
  end
`else
  assign pick_m0 = m0_elig;
  assign pick_m1 = m1_req_i && !m0_elig;
`endif

  mem_lane_merge u_merge (
    .old_word_i (s_rdata_i),
    .new_data_i (wdata_q),
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .merged_o   (merged_word)
  );

  // Everything is gated by rst so a reset cycle never issues a bus access or ack.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    grant_m0  = 1'b0;
    grant_m1  = 1'b0;
    m0_rd_fwd = 1'b0;
    m1_rd_fwd = 1'b0;
    s_req_o   = RIB_NREQ;
    s_we_o    = WriteDisable;
    s_wdata_o = ZeroWord;
    req_addr  = addr_q;
    m0_ack_o  = 1'b0;
    m1_ack_o  = 1'b0;
    if (!rst) begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_m0) begin
            grant_m0 = 1'b1;
            s_req_o  = RIB_REQ;
            req_addr = m0_addr_i;
            owner_d  = OWNER_M0;
            addr_d   = m0_addr_i;
            size_d   = m0_size_i;
            wdata_d  = m0_wdata_i;
            if (m0_we_i && !is_sub_word(m0_size_i)) begin
              s_we_o    = WriteEnable;
              s_wdata_o = m0_wdata_i;
              m0_ack_o  = 1'b1;
            end else if (m0_we_i) begin
              state_d = ARB_RMW;
            end else begin
              state_d = ARB_RD;
            end
          end else if (pick_m1) begin
            grant_m1 = 1'b1;
            s_req_o  = RIB_REQ;
            req_addr = m1_addr_i;
            owner_d  = OWNER_M1;
            addr_d   = m1_addr_i;
            state_d  = ARB_RD;
          end
        end
        ARB_RD: begin
          if (owner_q == OWNER_M1) begin
            m1_ack_o  = 1'b1;
            m1_rd_fwd = 1'b1;
          end else begin
            m0_ack_o  = 1'b1;
            m0_rd_fwd = 1'b1;
          end
          state_d = ARB_IDLE;
        end
        ARB_RMW: begin
          s_req_o   = RIB_REQ;
          s_we_o    = WriteEnable;
          s_wdata_o = merged_word;
          m0_ack_o  = 1'b1;
          state_d   = ARB_IDLE;
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  assign s_addr_o   = {req_addr[ADDR_W-1:2], 2'b00};
  assign m0_rdata_o = m0_rd_fwd ? s_rdata_i : m0_rdata_q;
  assign m1_rdata_o = m1_rd_fwd ? s_rdata_i : m1_rdata_q;
  assign hold_o     = !rst && m0_req_i && !m0_ack_o;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      owner_q    <= OWNER_M0;
      addr_q     <= '0;
      size_q     <= SIZE_W;
      wdata_q    <= ZeroWord;
      m0_rdata_q <= ZeroWord;
      m1_rdata_q <= ZeroWord;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wdata_q <= wdata_d;
      if (m0_rd_fwd) m0_rdata_q <= s_rdata_i;
      if (m1_rd_fwd) m1_rdata_q <= s_rdata_i;
    end
  end

endmodule

// File: tb/tb_mem_bus_arb.sv
// Directed bench for mem_bus_arb with a small single-port memory model behind the slave port.
module tb_mem_bus_arb;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req_i, m0_we_i;
  logic [1:0]        m0_size_i;
  logic [ADDR_W-1:0] m0_addr_i;
  logic [31:0]       m0_wdata_i, m0_rdata_o;
  logic              m0_ack_o;
  logic              m1_req_i;
  logic [ADDR_W-1:0] m1_addr_i;
  logic [31:0]       m1_rdata_o;
  logic              m1_ack_o;
  logic              int_assert_i;
  logic              s_req_o, s_we_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [31:0]       s_wdata_o;
  logic [31:0]       s_rdata_i;
  logic              hold_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:63];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;

  mem_bus_arb #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_size_i(m0_size_i), .m0_addr_i(m0_addr_i),
    .m0_wdata_i(m0_wdata_i), .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o),
    .m1_req_i(m1_req_i), .m1_addr_i(m1_addr_i), .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o),
    .int_assert_i(int_assert_i),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_rdata_i(s_rdata_i), .hold_o(hold_o)
  );

  always #5 clk = ~clk;

  // Memory model: read data is registered, so it is valid the cycle after a read request.
  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (s_req_o && s_we_o) mem[s_addr_o[7:2]] <= s_wdata_o;
    if (s_req_o && !s_we_o) s_rdata_i <= mem[s_addr_o[7:2]];
  end

  // ctl bundle order: {s_req, s_we, m0_ack, m1_ack, hold}
  wire [4:0] ctl = {s_req_o, s_we_o, m0_ack_o, m1_ack_o, hold_o};

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    cyc();
    pre_we   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m0_req_i = 1'b0; m1_req_i = 1'b0; int_assert_i = 1'b0;
    m0_we_i = 1'b0; m0_size_i = 2'b10; m0_addr_i = '0; m0_wdata_i = '0; m1_addr_i = '0;
    preload(6'd0, 32'h1122_3344);
    m0_req_i = 1'b1; m0_addr_i = 32'h100;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({ctl, s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got ctl=%b s_addr=%h s_wdata=%h m0_rdata=%h m1_rdata=%h exp all 0",
                 i, ctl, s_addr_o, s_wdata_o, m0_rdata_o, m1_rdata_o);
      end
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b10001 || s_addr_o !== 32'h100) begin
      errors++;
      $display("FAIL reset_first_req got ctl=%b s_addr=%h exp ctl=10001 s_addr=100", ctl, s_addr_o);
    end
    cyc();
    checks++;
    if (ctl !== 5'b00100 || m0_rdata_o !== 32'h1122_3344) begin
      errors++;
      $display("FAIL reset_load_ack got ctl=%b m0_rdata=%h exp ctl=00100 m0_rdata=11223344", ctl, m0_rdata_o);
    end
    cyc();
    m0_req_i = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b00000 || m0_rdata_o !== 32'h1122_3344) begin
      errors++;
      $display("FAIL rdata_hold got ctl=%b m0_rdata=%h exp ctl=00000 m0_rdata=11223344", ctl, m0_rdata_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_store_word();
    logic [31:0] addrs [2] = '{32'h104, 32'h10B};
    logic [1:0]  sizes [2] = '{2'b10, 2'b11};
    logic [31:0] datas [2] = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    logic [31:0] exp_addr [2] = '{32'h104, 32'h108};
    for (int i = 0; i < 2; i++) begin
      m0_req_i = 1'b1; m0_we_i = 1'b1; m0_size_i = sizes[i]; m0_addr_i = addrs[i]; m0_wdata_i = datas[i];
      #1;
      checks++;
      if (ctl !== 5'b11100 || s_addr_o !== exp_addr[i] || s_wdata_o !== datas[i]) begin
        errors++;
        $display("FAIL sw_same_cycle got ctl=%b s_addr=%h s_wdata=%h exp ctl=11100 s_addr=%h s_wdata=%h",
                 ctl, s_addr_o, s_wdata_o, exp_addr[i], datas[i]);
      end
      cyc();
      m0_req_i = 1'b0;
      #1;
      checks++;
      if (mem[exp_addr[i][7:2]] !== datas[i] || ctl !== 5'b00000) begin
        errors++;
        $display("FAIL sw_mem got mem=%h ctl=%b exp mem=%h ctl=00000", mem[exp_addr[i][7:2]], ctl, datas[i]);
      end
      $display("store word addr=%h data=%h", addrs[i], datas[i]);
    end
  endtask

  task automatic test_subword_store();
    logic [31:0] addrs [5] = '{32'h102, 32'h102, 32'h101, 32'h103, 32'h100};
    logic [1:0]  sizes [5] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00};
    logic [31:0] datas [5] = '{32'h1234_56AA, 32'h9999_BEEF, 32'h0000_5566, 32'hFFFF_FF77, 32'h0000_00C3};
    logic [31:0] olds  [5] = '{32'h1122_3344, 32'h1122_3344, 32'hBEEF_3344, 32'hBEEF_5566, 32'hA5A5_A5A5};
    logic [31:0] exps  [5] = '{32'h11AA_3344, 32'hBEEF_3344, 32'hBEEF_5566, 32'h77EF_5566, 32'hA5A5_A5C3};
    for (int i = 0; i < 5; i++) begin
      preload(6'd0, olds[i]);
      m0_req_i = 1'b1; m0_we_i = 1'b1; m0_size_i = sizes[i]; m0_addr_i = addrs[i]; m0_wdata_i = datas[i];
      #1;
      checks++;
      if (ctl !== 5'b10001 || s_addr_o !== 32'h100) begin
        errors++;
        $display("FAIL rmw_read[%0d] got ctl=%b s_addr=%h exp ctl=10001 s_addr=100", i, ctl, s_addr_o);
      end
      cyc();
      checks++;
      if (ctl !== 5'b11100 || s_addr_o !== 32'h100 || s_wdata_o !== exps[i]) begin
        errors++;
        $display("FAIL rmw_write[%0d] got ctl=%b s_addr=%h s_wdata=%h exp ctl=11100 s_addr=100 s_wdata=%h",
                 i, ctl, s_addr_o, s_wdata_o, exps[i]);
      end
      cyc();
      m0_req_i = 1'b0;
      #1;
      checks++;
      if (mem[0] !== exps[i] || ctl !== 5'b00000) begin
        errors++;
        $display("FAIL rmw_mem[%0d] got mem=%h ctl=%b exp mem=%h ctl=00000", i, mem[0], ctl, exps[i]);
      end
      $display("subword store addr=%h size=%0d old=%h new=%h", addrs[i], sizes[i], olds[i], exps[i]);
    end
  endtask

  task automatic test_load();
    logic [31:0] addrs [2] = '{32'h107, 32'h109};
    logic [1:0]  sizes [2] = '{2'b10, 2'b00};
    logic [31:0] exp_addr [2] = '{32'h104, 32'h108};
    logic [31:0] exp_data [2] = '{32'hDEAD_BEEF, 32'hCAFE_F00D};
    for (int i = 0; i < 2; i++) begin
      m0_req_i = 1'b1; m0_we_i = 1'b0; m0_size_i = sizes[i]; m0_addr_i = addrs[i];
      #1;
      checks++;
      if (ctl !== 5'b10001 || s_addr_o !== exp_addr[i]) begin
        errors++;
        $display("FAIL load_req got ctl=%b s_addr=%h exp ctl=10001 s_addr=%h", ctl, s_addr_o, exp_addr[i]);
      end
      cyc();
      checks++;
      if (ctl !== 5'b00100 || m0_rdata_o !== exp_data[i]) begin
        errors++;
        $display("FAIL load_ack got ctl=%b m0_rdata=%h exp ctl=00100 m0_rdata=%h", ctl, m0_rdata_o, exp_data[i]);
      end
      cyc();
      m0_req_i = 1'b0;
      $display("load addr=%h data=%h", addrs[i], m0_rdata_o);
    end
  endtask

  task automatic test_contention();
    pulse_reset();
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_size_i = 2'b10; m0_addr_i = 32'h104;
    m1_req_i = 1'b1; m1_addr_i = 32'h108;
    #1;
    checks++;
    if (ctl !== 5'b10001 || s_addr_o !== 32'h104) begin
      errors++;
      $display("FAIL contention_grant got ctl=%b s_addr=%h exp ctl=10001 s_addr=104", ctl, s_addr_o);
    end
    cyc();
    checks++;
    if (ctl !== 5'b00100 || m0_rdata_o !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL contention_m0_ack got ctl=%b m0_rdata=%h exp ctl=00100 m0_rdata=deadbeef", ctl, m0_rdata_o);
    end
    cyc();
    m0_req_i = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b10000 || s_addr_o !== 32'h108) begin
      errors++;
      $display("FAIL contention_m1_grant got ctl=%b s_addr=%h exp ctl=10000 s_addr=108", ctl, s_addr_o);
    end
    cyc();
    checks++;
    if (ctl !== 5'b00010 || m1_rdata_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL contention_m1_ack got ctl=%b m1_rdata=%h exp ctl=00010 m1_rdata=cafef00d", ctl, m1_rdata_o);
    end
    cyc();
    m1_req_i = 1'b0;
    $display("contention m0 then m1 done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] win_addr, lose_addr;
    logic [4:0]  win_ctl, lose_grant_ctl, lose_ack_ctl;
    logic        m1_first;
`ifdef MEM_BUS_ARB_RR_EN
    m1_first = 1'b1;
    win_addr = 32'h108; lose_addr = 32'h100;
    win_ctl = 5'b00011; lose_grant_ctl = 5'b10001; lose_ack_ctl = 5'b00100;
`else
    m1_first = 1'b0;
    win_addr = 32'h100; lose_addr = 32'h108;
    win_ctl = 5'b00100; lose_grant_ctl = 5'b10000; lose_ack_ctl = 5'b00010;
`endif
    pulse_reset();
    m0_req_i = 1'b1; m0_we_i = 1'b0; m0_size_i = 2'b10; m0_addr_i = 32'h104;
    m1_req_i = 1'b1; m1_addr_i = 32'h108;
    cyc();
    cyc();
    m0_addr_i = 32'h100;
    #1;
    checks++;
    if (ctl !== 5'b10001 || s_addr_o !== win_addr) begin
      errors++;
      $display("FAIL b2b_tie_grant got ctl=%b s_addr=%h exp ctl=10001 s_addr=%h", ctl, s_addr_o, win_addr);
    end
    cyc();
    checks++;
    if (ctl !== win_ctl) begin
      errors++;
      $display("FAIL b2b_win_ack got ctl=%b exp ctl=%b", ctl, win_ctl);
    end
    cyc();
    if (m1_first) m1_req_i = 1'b0;
    else m0_req_i = 1'b0;
    #1;
    checks++;
    if (ctl !== lose_grant_ctl || s_addr_o !== lose_addr) begin
      errors++;
      $display("FAIL b2b_lose_grant got ctl=%b s_addr=%h exp ctl=%b s_addr=%h", ctl, s_addr_o, lose_grant_ctl, lose_addr);
    end
    cyc();
    checks++;
    if (ctl !== lose_ack_ctl || m0_rdata_o !== 32'hA5A5_A5C3 || m1_rdata_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL b2b_lose_ack got ctl=%b m0_rdata=%h m1_rdata=%h exp ctl=%b m0_rdata=a5a5a5c3 m1_rdata=cafef00d",
               ctl, m0_rdata_o, m1_rdata_o, lose_ack_ctl);
    end
    cyc();
    m0_req_i = 1'b0; m1_req_i = 1'b0;
    $display("back-to-back tie served m1 first=%0d", m1_first);
  endtask

  task automatic test_int_assert();
    preload(6'd3, 32'h0);
    int_assert_i = 1'b1;
    m0_req_i = 1'b1; m0_we_i = 1'b1; m0_size_i = 2'b10; m0_addr_i = 32'h10C; m0_wdata_i = 32'h5555_5555;
    m1_req_i = 1'b1; m1_addr_i = 32'h108;
    #1;
    checks++;
    if (ctl !== 5'b10001 || s_addr_o !== 32'h108) begin
      errors++;
      $display("FAIL int_m1_grant got ctl=%b s_addr=%h exp ctl=10001 s_addr=108", ctl, s_addr_o);
    end
    cyc();
    checks++;
    if (ctl !== 5'b00011 || m1_rdata_o !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL int_m1_ack got ctl=%b m1_rdata=%h exp ctl=00011 m1_rdata=cafef00d", ctl, m1_rdata_o);
    end
    cyc();
    m1_req_i = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b00001 || mem[3] !== 32'h0) begin
      errors++;
      $display("FAIL int_blocks_m0 got ctl=%b mem=%h exp ctl=00001 mem=00000000", ctl, mem[3]);
    end
    int_assert_i = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b11100 || s_addr_o !== 32'h10C) begin
      errors++;
      $display("FAIL int_release_sw got ctl=%b s_addr=%h exp ctl=11100 s_addr=10c", ctl, s_addr_o);
    end
    cyc();
    m0_req_i = 1'b0;
    #1;
    checks++;
    if (mem[3] !== 32'h5555_5555) begin
      errors++;
      $display("FAIL int_sw_mem got %h exp 55555555", mem[3]);
    end
    preload(6'd0, 32'h1122_3344);
    m0_req_i = 1'b1; m0_we_i = 1'b1; m0_size_i = 2'b00; m0_addr_i = 32'h101; m0_wdata_i = 32'h0000_0066;
    cyc();
    int_assert_i = 1'b1;
    #1;
    checks++;
    if (ctl !== 5'b11100 || s_wdata_o !== 32'h1122_6644) begin
      errors++;
      $display("FAIL int_during_rmw got ctl=%b s_wdata=%h exp ctl=11100 s_wdata=11226644", ctl, s_wdata_o);
    end
    cyc();
    m0_req_i = 1'b0; int_assert_i = 1'b0;
    #1;
    checks++;
    if (mem[0] !== 32'h1122_6644) begin
      errors++;
      $display("FAIL int_rmw_mem got %h exp 11226644", mem[0]);
    end
    $display("int_assert gating done");
  endtask

  task automatic test_reset_mid_rmw();
    preload(6'd0, 32'h1122_3344);
    m0_req_i = 1'b1; m0_we_i = 1'b1; m0_size_i = 2'b00; m0_addr_i = 32'h100; m0_wdata_i = 32'h0000_0099;
    #1;
    checks++;
    if (ctl !== 5'b10001) begin
      errors++;
      $display("FAIL midrmw_read got ctl=%b exp ctl=10001", ctl);
    end
    cyc();
    rst = 1'b1;
    #1;
    checks++;
    if (ctl !== 5'b00000) begin
      errors++;
      $display("FAIL midrmw_reset_outs got ctl=%b exp ctl=00000", ctl);
    end
    cyc();
    m0_req_i = 1'b0; rst = 1'b0;
    #1;
    checks++;
    if (mem[0] !== 32'h1122_3344 || ctl !== 5'b00000) begin
      errors++;
      $display("FAIL midrmw_no_write got mem=%h ctl=%b exp mem=11223344 ctl=00000", mem[0], ctl);
    end
    $display("reset mid-rmw abandoned access");
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_subword_store();
    test_load();
    test_contention();
    test_back_to_back();
    test_int_assert();
    test_reset_mid_rmw();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
